// File: rtl/player_ctrl_param.sv
// Player motion and lives controller.
// Once per frame: applies pending hits, steps the horizontal speed toward the
// key-selected target, integrates the fixed-point X position and clamps it to
// the visible area. Handles invulnerability frames, game over and restart.
module player_ctrl_param #(
    parameter int INITIAL_X     = 280,
    parameter int Y_POS         = 300,
    parameter int OBJECT_WIDTH  = 32,
    parameter int SCREEN_WIDTH  = 640,
    parameter int MARGIN        = 2,
    parameter int FP_SHIFT      = 6,
    parameter int MAX_SPEED     = 50,
    parameter int ACCEL         = 10,
    parameter int LIVES_W       = 3,
    parameter int INITIAL_LIVES = 3,
    parameter int INVULN_FRAMES = 60
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                startOfFrame,
    input  logic                rightKey,
    input  logic                leftKey,
    input  logic                shotHit,
    input  logic                monsterHit,
    input  logic                restart,
    output logic signed [10:0]  topLeftX,
    output logic signed [10:0]  topLeftY,
    output logic [LIVES_W-1:0]  lives,
    output logic                wasShot,
    output logic                invulnerable,
    output logic                gameOver
);

    // Counter only needs to hold INVULN_FRAMES; keep at least one bit when disabled.
    localparam int CNT_W = (INVULN_FRAMES > 0) ? $clog2(INVULN_FRAMES + 1) : 1;

    localparam logic signed [31:0] X_INIT  = INITIAL_X << FP_SHIFT;
    localparam logic signed [31:0] X_LO    = MARGIN << FP_SHIFT;
    localparam logic signed [31:0] X_HI    = (SCREEN_WIDTH - 1 - MARGIN - OBJECT_WIDTH) << FP_SHIFT;
    localparam logic signed [31:0] MAX_S   = MAX_SPEED;
    localparam logic signed [31:0] ACC     = ACCEL;
    localparam logic signed [10:0] X_PIX0  = 11'(INITIAL_X);
    localparam logic signed [10:0] Y_PIX   = 11'(Y_POS);
    localparam logic [LIVES_W-1:0] LIVES0  = LIVES_W'(INITIAL_LIVES);
    localparam logic [CNT_W-1:0]   INV0    = CNT_W'(INVULN_FRAMES);

    typedef enum logic [2:0] {
        IDLE_ST,
        COLLECT_ST,
        FRAME_ST,
        MOVE_ST,
        LIMIT_ST,
        DEAD_ST
    } state_t;

    state_t               state_q;
    logic signed [31:0]   xpos_q;
    logic signed [31:0]   speed_q;
    logic signed [10:0]   top_left_x_q;
    logic [LIVES_W-1:0]   lives_q;
    logic                 was_shot_q;
    logic                 game_over_q;
    logic [CNT_W-1:0]     invuln_cnt_q;
    logic                 shot_latch_q;
    logic                 monster_latch_q;

    logic                 shot_latch_d;
    logic                 monster_latch_d;
    logic signed [31:0]   target_speed;
    logic signed [31:0]   speed_d;
    logic signed [31:0]   xpos_clamped;
    logic                 clamp_hit;
    logic [LIVES_W-1:0]   lives_dec;

    // Sticky hit latches: active from COLLECT through LIMIT, cleared by FRAME
    // (a hit arriving during FRAME itself still survives to the next frame).
    always_comb begin
        shot_latch_d    = 1'b0;
        monster_latch_d = 1'b0;
        if (state_q == COLLECT_ST || state_q == FRAME_ST ||
            state_q == MOVE_ST    || state_q == LIMIT_ST) begin
            shot_latch_d    = (shot_latch_q & ~(state_q == FRAME_ST))
                              | (shotHit & (invuln_cnt_q == '0));
            monster_latch_d = (monster_latch_q & ~(state_q == FRAME_ST)) | monsterHit;
        end
    end

    // Target speed from the keys and the accelerated step toward it.
    always_comb begin
        target_speed = '0;
        if (rightKey && !leftKey) begin
            target_speed = MAX_S;
        end else if (leftKey && !rightKey) begin
            target_speed = -MAX_S;
        end
        speed_d = target_speed;
        if (ACCEL != 0) begin
            if (speed_q < target_speed) begin
                speed_d = ((target_speed - speed_q) > ACC) ? speed_q + ACC : target_speed;
            end else if (speed_q > target_speed) begin
                speed_d = ((speed_q - target_speed) > ACC) ? speed_q - ACC : target_speed;
            end else begin
                speed_d = speed_q;
            end
        end
    end

    // Screen clamp of the integrated position and saturating life decrement.
    always_comb begin
        xpos_clamped = xpos_q;
        clamp_hit    = 1'b0;
        if (xpos_q < X_LO) begin
            xpos_clamped = X_LO;
            clamp_hit    = 1'b1;
        end else if (xpos_q > X_HI) begin
            xpos_clamped = X_HI;
            clamp_hit    = 1'b1;
        end
        lives_dec = (lives_q == '0) ? '0 : lives_q - 1'b1;
    end

    // Main frame sequencer with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE_ST;
            xpos_q          <= X_INIT;
            speed_q         <= '0;
            top_left_x_q    <= X_PIX0;
            lives_q         <= LIVES0;
            was_shot_q      <= 1'b0;
            game_over_q     <= 1'b0;
            invuln_cnt_q    <= '0;
            shot_latch_q    <= 1'b0;
            monster_latch_q <= 1'b0;
        end else begin
            was_shot_q      <= 1'b0;
            shot_latch_q    <= shot_latch_d;
            monster_latch_q <= monster_latch_d;
            case (state_q)
                IDLE_ST: begin
                    if (startOfFrame) begin
                        state_q <= COLLECT_ST;
                    end
                end
                COLLECT_ST: begin
                    if (startOfFrame) begin
                        state_q <= FRAME_ST;
                    end
                end
                FRAME_ST: begin
                    if (monster_latch_q) begin
                        lives_q     <= '0;
                        game_over_q <= 1'b1;
                        state_q     <= DEAD_ST;
                    end else if (shot_latch_q) begin
                        lives_q      <= lives_dec;
                        was_shot_q   <= 1'b1;
                        invuln_cnt_q <= INV0;
                        if (lives_dec == '0) begin
                            game_over_q <= 1'b1;
                            state_q     <= DEAD_ST;
                        end else begin
                            speed_q <= speed_d;
                            state_q <= MOVE_ST;
                        end
                    end else begin
                        if (invuln_cnt_q != '0) begin
                            invuln_cnt_q <= invuln_cnt_q - 1'b1;
                        end
                        speed_q <= speed_d;
                        state_q <= MOVE_ST;
                    end
                end
                MOVE_ST: begin
                    xpos_q  <= xpos_q + speed_q;
                    state_q <= LIMIT_ST;
                end
                LIMIT_ST: begin
                    xpos_q       <= xpos_clamped;
                    top_left_x_q <= 11'(xpos_clamped >>> FP_SHIFT);
                    if (clamp_hit) begin
                        speed_q <= '0;
                    end
                    state_q <= COLLECT_ST;
                end
                DEAD_ST: begin
                    if (restart) begin
                        state_q      <= IDLE_ST;
                        xpos_q       <= X_INIT;
                        speed_q      <= '0;
                        top_left_x_q <= X_PIX0;
                        lives_q      <= LIVES0;
                        game_over_q  <= 1'b0;
                        invuln_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE_ST;
                end
            endcase
        end
    end

    assign topLeftX     = top_left_x_q;
    assign topLeftY     = Y_PIX;
    assign lives        = lives_q;
    assign wasShot      = was_shot_q;
    assign invulnerable = (invuln_cnt_q != '0);
    assign gameOver     = game_over_q;

endmodule
